// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: write port, two read ports and scoreboard.
// master drives addresses/data/issue marks; slave returns read data and busy status.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;
  logic              busy1;
  logic              busy2;
  logic              any_busy;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
    input  rdata1, rdata2, busy1, busy2, any_busy
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, busy_set, busy_addr,
    output rdata1, rdata2, busy1, busy2, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;
  logic              set_ok;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              bz1;
  logic              bz2;

  assign wr_ok  = bus.we && !(ZERO_REG && (bus.waddr == '0));
  assign set_ok = bus.busy_set && !(ZERO_REG && (bus.busy_addr == '0));

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[bus.waddr]     = 1'b0;
    if (set_ok) busy_nxt[bus.busy_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) mem[bus.waddr] <= bus.wdata;
      busy <= busy_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // No forwarding when a new producer claims the same register this edge.
  logic byp_ok;
  assign byp_ok = wr_ok && !(set_ok && (bus.busy_addr == bus.waddr));
`endif

  always_comb begin
    rd1 = mem[bus.raddr1];
    bz1 = busy[bus.raddr1];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (bus.raddr1 == bus.waddr)) begin
      rd1 = bus.wdata;
      bz1 = 1'b0;
    end
`endif
    if (ZERO_REG && (bus.raddr1 == '0)) begin
      rd1 = '0;
      bz1 = 1'b0;
    end
  end

  always_comb begin
    rd2 = mem[bus.raddr2];
    bz2 = busy[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (bus.raddr2 == bus.waddr)) begin
      rd2 = bus.wdata;
      bz2 = 1'b0;
    end
`endif
    if (ZERO_REG && (bus.raddr2 == '0)) begin
      rd2 = '0;
      bz2 = 1'b0;
    end
  end

  assign bus.rdata1   = rd1;
  assign bus.rdata2   = rd2;
  assign bus.busy1    = bz1;
  assign bus.busy2    = bz2;
  assign bus.any_busy = |busy;
endmodule
